// File: rtl/l1_thresh_wb_target.sv
// Wishbone target for the L1 trigger threshold port.
// Holds per-beam threshold and sub-threshold registers. A CTRL start command
// streams the whole set (thresholds first, then sub-thresholds) to the
// beam-threshold loaders. Register writes arriving while the stream is being
// produced are held off, so the datapath only ever sees a consistent set.
//
// Stream handshake: a word moves on every rising clock edge where
// thr_tvalid_o and thr_tready_i are both high. Once thr_tvalid_o rises,
// thr_tdata_o, thr_tuser_o and thr_tlast_o stay fixed until that transfer,
// and thr_tvalid_o never falls without a transfer.
module l1_thresh_wb_target #(
    parameter int NBEAMS         = 46,
    parameter int THRESH_BITS    = 18,
    parameter int THRESH_DEFAULT = 4000
) (
    input  logic                   wb_clk_i,
    input  logic                   wb_rst_ni,
    input  logic                   wb_cyc_i,
    input  logic                   wb_stb_i,
    input  logic                   wb_we_i,
    input  logic [12:0]            wb_adr_i,
    input  logic [31:0]            wb_dat_i,
    input  logic [3:0]             wb_sel_i,
    output logic                   wb_ack_o,
    output logic                   wb_err_o,
    output logic                   wb_rty_o,
    output logic [31:0]            wb_dat_o,
    output logic [THRESH_BITS-1:0] thr_tdata_o,
    output logic [7:0]             thr_tuser_o,
    output logic                   thr_tvalid_o,
    input  logic                   thr_tready_i,
    output logic                   thr_tlast_o,
    output logic                   update_done_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_DONE} state_t;

    localparam logic [8:0]             LAST_IDX = 9'(2 * NBEAMS - 1);
    localparam logic [8:0]             NB9      = 9'(NBEAMS);
    localparam logic [10:0]            NB11     = 11'(NBEAMS);
    localparam logic [7:0]             NB8      = 8'(NBEAMS);
    localparam logic [THRESH_BITS-1:0] DEF_VAL  = THRESH_BITS'(THRESH_DEFAULT);

    state_t                 state, state_nxt;
    logic [THRESH_BITS-1:0] thr_q [NBEAMS];
    logic [THRESH_BITS-1:0] sub_q [NBEAMS];
    logic [15:0]            upd_count;
    logic [8:0]             idx;

    logic        is_ctrl, is_cnt, is_thr, is_sub, in_range, reg_hit;
    logic        stall, accept, start;
    logic        busy, done_pulse, xfer, load_word;
    logic [6:0]  n;
    logic [31:0] rd_data;
    logic [8:0]  nxt_idx, sub_idx;
    logic        nxt_is_sub;
    logic [6:0]  nxt_beam;
    logic [THRESH_BITS-1:0] nxt_data;
    logic        unused_inputs;

    // Address decode; beam index is only trusted once in_range holds.
    assign is_ctrl  = (wb_adr_i == 13'h0000);
    assign is_cnt   = (wb_adr_i == 13'h0001);
    assign is_thr   = (wb_adr_i[12:11] == 2'b01);
    assign is_sub   = (wb_adr_i[12:11] == 2'b10);
    assign in_range = (wb_adr_i[10:0] < NB11);
    assign n        = wb_adr_i[6:0];
    assign reg_hit  = (is_thr | is_sub) & in_range;

    // Only register-file writes wait; the DONE cycle is already safe to write.
    assign stall  = wb_we_i & reg_hit & ((state == S_LOAD) | (state == S_STREAM));
    assign accept = wb_cyc_i & wb_stb_i & ~wb_ack_o & ~stall;
    assign start  = accept & wb_we_i & is_ctrl & wb_dat_i[0];

    assign wb_err_o = 1'b0;
    assign wb_rty_o = 1'b0;

    assign unused_inputs = ^{wb_sel_i, wb_dat_i, sub_idx};

    // State register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Next-state logic: IDLE -> LOAD -> STREAM (until last word moves) -> DONE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_LOAD;
            S_LOAD:   state_nxt = S_STREAM;
            S_STREAM: if (xfer && idx == LAST_IDX) state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs and stream-advance strobes.
    always_comb begin
        busy       = (state != S_IDLE);
        done_pulse = (state == S_DONE);
        xfer       = thr_tvalid_o & thr_tready_i;
        load_word  = (state == S_LOAD) | ((state == S_STREAM) & xfer & (idx != LAST_IDX));
    end

    assign update_done_o = done_pulse;

    // Select the word to be registered next (index 0 when entering LOAD).
    always_comb begin
        nxt_idx    = (state == S_LOAD) ? 9'd0 : idx + 9'd1;
        sub_idx    = nxt_idx - NB9;
        nxt_is_sub = (nxt_idx >= NB9);
        nxt_beam   = nxt_is_sub ? sub_idx[6:0] : nxt_idx[6:0];
        nxt_data   = nxt_is_sub ? sub_q[nxt_beam] : thr_q[nxt_beam];
    end

    // Stream output register: load a word, or drop valid after the final transfer.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            idx          <= 9'd0;
            thr_tvalid_o <= 1'b0;
            thr_tdata_o  <= '0;
            thr_tuser_o  <= 8'h00;
            thr_tlast_o  <= 1'b0;
        end else if (load_word) begin
            idx          <= nxt_idx;
            thr_tvalid_o <= 1'b1;
            thr_tdata_o  <= nxt_data;
            thr_tuser_o  <= {nxt_is_sub, nxt_beam};
            thr_tlast_o  <= (nxt_idx == LAST_IDX);
        end else if (xfer) begin
            thr_tvalid_o <= 1'b0;
            thr_tlast_o  <= 1'b0;
        end
    end

    // Threshold register file.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            for (int i = 0; i < NBEAMS; i++) begin
                thr_q[i] <= DEF_VAL;
                sub_q[i] <= DEF_VAL;
            end
        end else if (accept && wb_we_i && reg_hit) begin
            if (is_thr) thr_q[n] <= wb_dat_i[THRESH_BITS-1:0];
            else        sub_q[n] <= wb_dat_i[THRESH_BITS-1:0];
        end
    end

    // Completed-update counter, wraps naturally at 16 bits.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni)      upd_count <= 16'h0000;
        else if (done_pulse) upd_count <= upd_count + 16'h0001;
    end

    // Read-data mux; unmapped and out-of-range addresses read as zero.
    always_comb begin
        rd_data = 32'h0;
        if (is_ctrl)                rd_data = {16'h0, NB8, 6'h0, busy, 1'b0};
        else if (is_cnt)            rd_data = {16'h0, upd_count};
        else if (is_thr && in_range) rd_data = 32'(thr_q[n]);
        else if (is_sub && in_range) rd_data = 32'(sub_q[n]);
    end

    // Single-cycle ack with read data, zero whenever ack is low.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            wb_ack_o <= 1'b0;
            wb_dat_o <= 32'h0;
        end else begin
            wb_ack_o <= accept;
            wb_dat_o <= (accept && !wb_we_i) ? rd_data : 32'h0;
        end
    end

endmodule

// File: tb/tb_l1_thresh_wb_target.sv
// Directed bench for l1_thresh_wb_target: bus accesses with expected data,
// and a stream scoreboard fed from a register-file model.
module tb_l1_thresh_wb_target;
  localparam int NB  = 46;
  localparam int TB  = 18;
  localparam int W   = 8 + TB + 1;
  localparam int DEF = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cyc = 0, stb = 0, we = 0;
  logic [12:0]   adr = '0;
  logic [31:0]   dat_i = '0;
  logic [3:0]    sel = 4'hF;
  logic          ack, err, rty;
  logic [31:0]   dat_o;
  logic [TB-1:0] tdata;
  logic [7:0]    tuser;
  logic          tvalid, tready, tlast, done;

  l1_thresh_wb_target dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .wb_cyc_i(cyc), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(dat_i), .wb_sel_i(sel),
    .wb_ack_o(ack), .wb_err_o(err), .wb_rty_o(rty), .wb_dat_o(dat_o),
    .thr_tdata_o(tdata), .thr_tuser_o(tuser), .thr_tvalid_o(tvalid),
    .thr_tready_i(tready), .thr_tlast_o(tlast), .update_done_o(done)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail = 0;
  int cyc_cnt = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int first_xfer_cyc = 0;
  int ack_cyc = 0;
  int word_no = 0;
  int last_cnt = 0;
  int exp_cnt = 0;
  logic tvalid_at_ack = 0;
  logic rdy_rand = 0;

  logic [TB-1:0] exp_thr [NB];
  logic [TB-1:0] exp_sub [NB];
  logic [W-1:0]  exp_q[$];
  logic [7:0]    cap_tuser [2*NB];
  logic [TB-1:0] cap_tdata [2*NB];

  always @(posedge clk) cyc_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, expv);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      exp_thr[k] = TB'(DEF);
      exp_sub[k] = TB'(DEF);
    end
    exp_cnt = 0;
  endtask

  // ---------------- stream ready driver ----------------
  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- scoreboard / compare process ----------------
  logic         prev_stall = 0;
  logic [W-1:0] prev_word = '0;

  always @(negedge clk) begin
    logic [W-1:0] cur;
    logic [W-1:0] expw;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      cur = {tuser, tdata, tlast};
      if (!ack) chk("dat_zero_without_ack", dat_o, 0);
      chk("err_rty_zero", {err, rty}, 0);
      if (prev_stall) begin
        chk("tvalid_held", tvalid, 1);
        chk("word_stable", cur, prev_word);
      end
      if (tvalid && tready) begin
        if (word_no == 0) first_xfer_cyc = cyc_cnt;
        if (exp_q.size() == 0) begin
          chk("unexpected_word", cur, 0);
        end else begin
          expw = exp_q.pop_front();
          chk("stream_word", cur, expw);
        end
        if (word_no < 2*NB) begin
          cap_tuser[word_no] = tuser;
          cap_tdata[word_no] = tdata;
        end
        if (tlast) last_cnt++;
        word_no++;
      end
      prev_stall = tvalid && !tready;
      prev_word  = cur;
      if (done) begin
        done_cnt++;
        done_cyc = cyc_cnt;
        chk("done_after_all_words", exp_q.size(), 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wb_xfer(input logic w, input logic [12:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int lat);
    @(posedge clk);
    #1;
    cyc = 1; stb = 1; we = w; adr = a; dat_i = d;
    lat = 0;
    rd = '0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      lat++;
      if (ack) break;
    end
    if (!ack) chk("ack_timeout", 1, 0);
    rd = dat_o;
    ack_cyc = cyc_cnt;
    tvalid_at_ack = tvalid;
    @(posedge clk);
    #1;
    cyc = 0; stb = 0; we = 0;
    @(negedge clk);
    chk("ack_single_cycle", ack, 0);
  endtask

  task automatic rd_chk(input string name, input logic [12:0] a, input logic [31:0] expv);
    logic [31:0] rd;
    int lat;
    wb_xfer(0, a, 32'h0, rd, lat);
    chk(name, rd, expv);
    chk("read_latency", lat, 2);
  endtask

  task automatic wr_now(input logic [12:0] a, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    wb_xfer(1, a, d, rd, lat);
    chk("write_latency", lat, 2);
  endtask

  // Queue the snapshot, then issue the start command.
  task automatic do_update(output int done0);
    logic [31:0] rd;
    int lat;
    word_no = 0;
    last_cnt = 0;
    done0 = done_cnt;
    for (int k = 0; k < NB; k++) exp_q.push_back({1'b0, 7'(k), exp_thr[k], 1'b0});
    for (int k = 0; k < NB; k++) exp_q.push_back({1'b1, 7'(k), exp_sub[k], k == NB-1});
    wb_xfer(1, 13'h0000, 32'h1, rd, lat);
    chk("start_latency", lat, 2);
    chk("tvalid_low_in_load", tvalid_at_ack, 0);
    chk("tvalid_high_after_load", tvalid, 1);
  endtask

  task automatic wait_update(input int done0);
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt != done0) break;
      @(negedge clk);
    end
    chk("update_done_seen", done_cnt != done0, 1);
    @(negedge clk);
    chk("done_pulse_count", done_cnt - done0, 1);
    chk("word_count", word_no, 2*NB);
    chk("tlast_count", last_cnt, 1);
    chk("queue_drained", exp_q.size(), 0);
    exp_cnt++;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] rd;
    int lat;
    int d0;
    model_reset();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_outputs", {ack, dat_o, tvalid, tlast, tdata, tuser, done}, 0);
    @(posedge clk);
    #1 rst_n = 1;

    rd_chk("thresh0_default", 13'h0800, 32'd4000);
    rd_chk("subthresh45_default", 13'h1000 + 13'd45, 32'd4000);
    rd_chk("ctrl_idle", 13'h0000, 32'h00002E00);
    rd_chk("upd_count_reset", 13'h0001, 32'h0);

    // Truncation and out-of-range/unmapped addresses
    wr_now(13'h0805, 32'hFFFFFFFF);
    exp_thr[5] = '1;
    rd_chk("thresh5_trunc", 13'h0805, 32'h0003FFFF);
    wr_now(13'h0800 + 13'd46, 32'h00012345);
    rd_chk("thresh46_ignored", 13'h0800 + 13'd46, 32'h0);
    rd_chk("unmapped_read", 13'h1800, 32'h0);
    wr_now(13'h0800, 32'h1);           exp_thr[0]  = 18'h1;
    wr_now(13'h082D, 32'h7);           exp_thr[45] = 18'h7;
    wr_now(13'h102D, 32'h2AAAA);       exp_sub[45] = 18'h2AAAA;
    rd_chk("subthresh45_model", 13'h102D, 32'(exp_sub[45]));

    // Update with tready held high; busy readback and ignored restart mid-stream
    do_update(d0);
    rd_chk("ctrl_busy", 13'h0000, 32'h00002E02);
    wr_now(13'h0000, 32'h1);
    wait_update(d0);
    chk("first_tuser", cap_tuser[0], 8'h00);
    chk("first_tdata", cap_tdata[0], 18'h1);
    chk("word46_tuser", cap_tuser[46], 8'h80);
    chk("last_tuser", cap_tuser[91], 8'hAD);
    chk("last_tdata", cap_tdata[91], 18'h2AAAA);
    chk("done_timing", done_cyc - first_xfer_cyc, 2*NB);
    rd_chk("upd_count_one", 13'h0001, 32'h1);
    rd_chk("ctrl_idle_after", 13'h0000, 32'h00002E00);

    // Update with random backpressure
    wr_now(13'h080A, 32'h155);   exp_thr[10] = 18'h155;
    wr_now(13'h1003, 32'h3FFFE); exp_sub[3]  = 18'h3FFFE;
    rdy_rand = 1;
    do_update(d0);
    wait_update(d0);
    rdy_rand = 0;
    chk("rand_thresh10", cap_tdata[10], 18'h155);
    rd_chk("upd_count_model", 13'h0001, 32'(exp_cnt));

    // Register write during an update is stalled until after DONE
    do_update(d0);
    wb_xfer(1, 13'h1000, 32'd123, rd, lat);
    chk("stalled_ack_after_done", ack_cyc, done_cyc + 1);
    chk("stall_was_long", lat > 2, 1);
    exp_sub[0] = 18'd123;
    wait_update(d0);
    chk("old_sub0_streamed", cap_tdata[46], 18'd4000);
    do_update(d0);
    wait_update(d0);
    chk("new_sub0_streamed", cap_tdata[46], 18'd123);
    rd_chk("sub0_readback", 13'h1000, 32'd123);
    rd_chk("upd_count_four", 13'h0001, 32'h4);

    // Reset mid-stream
    do_update(d0);
    for (int k = 0; k < 500; k++) begin
      if (word_no >= 20) break;
      @(negedge clk);
    end
    chk("reached_word20", word_no >= 20, 1);
    #2 rst_n = 0;
    #1;
    chk("rst_mid_tvalid", tvalid, 0);
    chk("rst_mid_outputs", {ack, dat_o, tlast, tdata, tuser, done}, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    rd_chk("ctrl_after_rst", 13'h0000, 32'h00002E00);
    rd_chk("thresh5_after_rst", 13'h0805, 32'd4000);
    rd_chk("sub0_after_rst", 13'h1000, 32'd4000);
    rd_chk("upd_count_after_rst", 13'h0001, 32'h0);
    do_update(d0);
    wait_update(d0);
    rd_chk("upd_count_post_rst", 13'h0001, 32'(exp_cnt));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: got timeout, required completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
